memory_dp: RTL and testbench
============================

# memory_dp

Parametrised dual-port synchronous RAM: port A is read/write with byte-lane enables, port B is read-only. Both ports have registered reads with a configurable pipeline latency and a valid strobe. A built-in clear sequencer zeroes the whole array after reset or on request. It replaces the single-port, combinational-read `memory` wherever a CPU datapath needs one write/read port plus an independent fetch or debug read port.

## Interface
- `WIDTH`, 8: data width in bits; must be a multiple of 8.
- `LENGTH`, 256: number of words; need not be a power of two.
- `READ_LAT`, 1: read latency in cycles; legal values 1 or 2.
- `RDW_NEW`, 0: port B read of an address that port A writes in the same cycle; 0 returns old data, 1 returns new (byte-merged) data.
- Derived: `ADDR_WIDTH = $clog2(LENGTH)`, `LANES = WIDTH/8`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  request a full clear; sampled only while `busy`=0.
- `busy`  out  1  clear sequence in progress; while high, port requests are ignored.
- `a_en`  in  1  port A access request.
- `a_we`  in  1  port A write when `a_en`=1; otherwise read.
- `a_be`  in  LANES  port A byte enables; bit i covers `a_wd[8i+7:8i]`.
- `a_addr`  in  ADDR_WIDTH  port A word address.
- `a_wd`  in  WIDTH  port A write data.
- `a_rd`  out  WIDTH  port A read data.
- `a_rvalid`  out  1  one-cycle strobe; `a_rd` is valid.
- `b_en`  in  1  port B read request.
- `b_addr`  in  ADDR_WIDTH  port B word address.
- `b_rd`  out  WIDTH  port B read data.
- `b_rvalid`  out  1  one-cycle strobe; `b_rd` is valid.

## Operation
- States:
  - CLEAR: `busy`=1; writes zero to word `cnt` each cycle, `cnt` counting 0..LENGTH-1. After writing word LENGTH-1, goes to IDLE.
  - IDLE: `busy`=0. `clr`=1 loads `cnt`=0 and goes to CLEAR.
- `rst_n` low: state CLEAR, `cnt`=0, both read pipelines flushed. Array contents are not reset; the sequencer zeroes them.
- Accepted accesses are those with `busy`=0 at the sampling edge. Requests while `busy`=1 are dropped: no write, no `rvalid`.
- Port A write (`a_en`=1, `a_we`=1): updates only the lanes with `a_be` bit set. `a_be`=0 is a no-op. Writes produce no `a_rvalid`.
- Port A read (`a_en`=1, `a_we`=0) and port B read (`b_en`=1): return the addressed word after `READ_LAT` cycles, with the matching `rvalid` strobe.
- `a_rd` and `b_rd` hold their last value when no read completes.
- Out-of-range address (≥ LENGTH): writes are dropped; reads return 0 with `rvalid` still asserted.
- Same-address, same-cycle A write and B read: `RDW_NEW`=0 gives the pre-write word. `RDW_NEW`=1 gives the pre-write word with the enabled lanes replaced by `a_wd`.
- `clr` in the same cycle as accepted accesses: the accesses complete normally and CLEAR begins next cycle. Reads already in the pipeline finish and return the data read at acceptance.
- `clr` while `busy`=1: ignored. It does not restart the count.

## Timing
- Reset values: `busy`=1, `a_rd`=0, `b_rd`=0, `a_rvalid`=0, `b_rvalid`=0.
- Clear duration:
  - Edge k after `rst_n` rises (k=1..LENGTH) zeroes word k-1.
  - `busy` falls after edge LENGTH.
  - The first request is accepted at edge LENGTH+1.
- Clear from IDLE: `clr` sampled at edge N, `busy`=1 after N, word j zeroed at edge N+1+j, `busy`=0 after edge N+LENGTH.
- Read latency:
  - Request sampled at edge N. With `READ_LAT`=1, `rd`/`rvalid` update after edge N; with `READ_LAT`=2, after edge N+1.
  - Full throughput: one read per port per cycle.
- Write latency: the array updates at the sampling edge. A port A read of the same address on the next cycle sees the new data.
- `rst_n` asserted mid-read or mid-clear: outputs go to reset values immediately; in-flight reads are lost; CLEAR restarts from word 0.

## Test plan
- Reset with LENGTH=256, release `rst_n` -> `busy` stays high for exactly 256 edges; then port B reads of addresses 0..255 all return 0x00.
- READ_LAT=2, write i to address i for i=0..9, then back-to-back A reads of 0..9 -> `a_rvalid` high for 10 consecutive cycles starting 2 cycles after the first request; `a_rd` = 0..9 in order.
- WIDTH=32: write 0xAABBCCDD with `a_be`=1111, then 0x11223344 with `a_be`=0101 to the same address -> read returns 0xAA22CC44.
- Same-cycle A write of 0x55 and B read of address 3 (old value 0x12) -> `b_rd`=0x12 with RDW_NEW=0; 0x55 with RDW_NEW=1.
- LENGTH=200: write to address 210, then read address 210 -> no array change; `b_rd`=0 with `b_rvalid`=1.
- Pulse `clr` in IDLE together with an A read; assert `a_en` during `busy`; pulse `rst_n` low mid-clear -> the first read completes; reads during `busy` give no `a_rvalid`; clear restarts from word 0 and `busy` lasts LENGTH edges.

Source files
------------

// File: rtl/memory_dp.sv
// Dual-port synchronous RAM: port A read/write with byte lanes, port B read-only.
// Registered reads with 1- or 2-cycle latency; a built-in sequencer zeroes the array.

module memory_dp #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LENGTH   = 256,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned RDW_NEW  = 0,
  localparam int unsigned ADDR_WIDTH = $clog2(LENGTH),
  localparam int unsigned LANES      = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [LANES-1:0]      a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wd,
  output logic [WIDTH-1:0]      a_rd,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [WIDTH-1:0]      b_rd,
  output logic                  b_rvalid
);

  localparam logic StIdle  = 1'b0;
  localparam logic StClear = 1'b1;

  // Clear sequencer
  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  cnt_last;

  assign busy     = (state_q == StClear);
  assign cnt_last = (32'(cnt_q) == LENGTH - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StClear: begin
        if (cnt_last) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request qualification
  logic accept;
  logic a_in_range, b_in_range;
  logic a_write, a_read, b_read;
  logic a_hit_b;

  assign accept     = ~busy;
  assign a_in_range = (32'(a_addr) < LENGTH);
  assign b_in_range = (32'(b_addr) < LENGTH);
  assign a_write    = accept & a_en & a_we & a_in_range;
  assign a_read     = accept & a_en & ~a_we;
  assign b_read     = accept & b_en;
  assign a_hit_b    = a_write & (a_addr == b_addr);

  // Storage; contents are deliberately not reset, the sequencer zeroes them.
  logic [WIDTH-1:0] mem_q [LENGTH];

  always_ff @(posedge clk) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (a_write) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (a_be[i]) begin
          mem_q[a_addr][8*i +: 8] <= a_wd[8*i +: 8];
        end
      end
    end
  end

  // Array read and read-during-write merge for port B
  logic [WIDTH-1:0] a_word, b_old, b_merged, b_word;

  assign a_word = a_in_range ? mem_q[a_addr] : '0;
  assign b_old  = b_in_range ? mem_q[b_addr] : '0;

  always_comb begin
    b_merged = b_old;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (a_hit_b && a_be[i]) begin
        b_merged[8*i +: 8] = a_wd[8*i +: 8];
      end
    end
  end

  assign b_word = (RDW_NEW != 0) ? b_merged : b_old;

  // Optional extra pipeline stage between array read and output register
  logic             a_done, b_done;
  logic [WIDTH-1:0] a_done_data, b_done_data;

  if (READ_LAT == 2) begin : g_lat2
    logic             a_pipe_valid_q, b_pipe_valid_q;
    logic [WIDTH-1:0] a_pipe_data_q, b_pipe_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_pipe_valid_q <= 1'b0;
        b_pipe_valid_q <= 1'b0;
        a_pipe_data_q  <= '0;
        b_pipe_data_q  <= '0;
      end else begin
        a_pipe_valid_q <= a_read;
        b_pipe_valid_q <= b_read;
        if (a_read) begin
          a_pipe_data_q <= a_word;
        end
        if (b_read) begin
          b_pipe_data_q <= b_word;
        end
      end
    end

    assign a_done      = a_pipe_valid_q;
    assign a_done_data = a_pipe_data_q;
    assign b_done      = b_pipe_valid_q;
    assign b_done_data = b_pipe_data_q;
  end else begin : g_lat1
    assign a_done      = a_read;
    assign a_done_data = a_word;
    assign b_done      = b_read;
    assign b_done_data = b_word;
  end

  // Output registers hold the last completed read
  logic             a_rvalid_q, b_rvalid_q;
  logic [WIDTH-1:0] a_rd_q, b_rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rd_q     <= '0;
      b_rd_q     <= '0;
    end else begin
      a_rvalid_q <= a_done;
      b_rvalid_q <= b_done;
      if (a_done) begin
        a_rd_q <= a_done_data;
      end
      if (b_done) begin
        b_rd_q <= b_done_data;
      end
    end
  end

  assign a_rd     = a_rd_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rd     = b_rd_q;
  assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_memory_dp.sv
// Bench for memory_dp: two instances (latency 1 / old-data, latency 2 / new-data) share
// stimulus and are compared every cycle against a transaction-level reference model.

module tb_memory_dp;

  localparam int unsigned W  = 32;
  localparam int unsigned L  = 200;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr, a_en, a_we, b_en;
  logic [3:0]    a_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wd;

  logic          busy0, a_rvalid0, b_rvalid0, busy1, a_rvalid1, b_rvalid1;
  logic [W-1:0]  a_rd0, b_rd0, a_rd1, b_rd1;

  memory_dp #(.WIDTH(W), .LENGTH(L), .READ_LAT(1), .RDW_NEW(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wd(a_wd),
    .a_rd(a_rd0), .a_rvalid(a_rvalid0),
    .b_en(b_en), .b_addr(b_addr), .b_rd(b_rd0), .b_rvalid(b_rvalid0)
  );

  memory_dp #(.WIDTH(W), .LENGTH(L), .READ_LAT(2), .RDW_NEW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wd(a_wd),
    .a_rd(a_rd1), .a_rvalid(a_rvalid1),
    .b_en(b_en), .b_addr(b_addr), .b_rd(b_rd1), .b_rvalid(b_rvalid1)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model. Read ports: 0 = A lat1, 1 = A lat2, 2 = B lat1 old, 3 = B lat2 new.
  typedef struct {
    int          port;
    int          due;
    logic [31:0] data;
  } pend_t;

  logic [31:0] m_mem [L];
  bit          m_busy;
  int          m_cnt;
  int          cyc = 0;
  pend_t       pend[$];
  logic [3:0]  e_v;
  logic [31:0] e_d [4];

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    pend.delete();
    e_v = '0;
    for (int k = 0; k < 4; k++) e_d[k] = '0;
  endtask

  task automatic push_read(input int port, input int due, input logic [31:0] data);
    pend_t p;
    p.port = port;
    p.due  = due;
    p.data = data;
    pend.push_back(p);
  endtask

  task automatic model_edge();
    logic [31:0] va, vb_old, vb_new;
    bit a_ok, b_ok;
    cyc++;
    a_ok = (int'(a_addr) < int'(L));
    b_ok = (int'(b_addr) < int'(L));
    if (!m_busy) begin
      if (b_en) begin
        vb_old = b_ok ? m_mem[b_addr] : 32'h0;
        vb_new = vb_old;
        if (a_en && a_we && a_ok && a_addr == b_addr) begin
          for (int i = 0; i < 4; i++) if (a_be[i]) vb_new[8*i +: 8] = a_wd[8*i +: 8];
        end
        push_read(2, cyc, vb_old);
        push_read(3, cyc + 1, vb_new);
      end
      if (a_en && !a_we) begin
        va = a_ok ? m_mem[a_addr] : 32'h0;
        push_read(0, cyc, va);
        push_read(1, cyc + 1, va);
      end
      if (a_en && a_we && a_ok) begin
        for (int i = 0; i < 4; i++) if (a_be[i]) m_mem[a_addr][8*i +: 8] = a_wd[8*i +: 8];
      end
      if (clr) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      m_mem[m_cnt] = 32'h0;
      m_cnt++;
      if (m_cnt == int'(L)) m_busy = 1'b0;
    end
    e_v = '0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        e_v[pend[i].port] = 1'b1;
        e_d[pend[i].port] = pend[i].data;
        pend.delete(i);
      end
    end
  endtask

  function automatic logic [133:0] obs_now();
    return {busy0, busy1, a_rvalid0, a_rd0, a_rvalid1, a_rd1,
            b_rvalid0, b_rd0, b_rvalid1, b_rd1};
  endfunction

  function automatic logic [133:0] exp_now();
    return {m_busy, m_busy, e_v[0], e_d[0], e_v[1], e_d[1],
            e_v[2], e_d[2], e_v[3], e_d[3]};
  endfunction

  task automatic drive(input logic en, input logic we, input logic [3:0] be,
                       input logic [AW-1:0] addr, input logic [W-1:0] wd,
                       input logic ben, input logic [AW-1:0] baddr, input logic c);
    a_en = en; a_we = we; a_be = be; a_addr = addr; a_wd = wd;
    b_en = ben; b_addr = baddr; clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_now() !== exp_now())
      begin n_bad++; $display("FAIL reset_values: got %h want %h", obs_now(), exp_now()); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick(); n++; n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL clear_run cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end while (busy0 === 1'b1 && n < int'(L) + 20);
    n_vec++;
    if (n != int'(L)) begin n_bad++; $display("FAIL clear_len: got %0d edges want %0d", n, L); end
    for (int i = 0; i < int'(L) + 2; i++) begin
      if (i < int'(L)) drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, AW'(i), 1'b0);
      else idle();
      tick(); n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL clear_zero cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end
  endtask

  task automatic test_burst();
    int req_edge, first, run;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 4'hf, AW'(i), W'(i), 1'b0, '0, 1'b0);
      tick(); n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL burst_wr cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end
    req_edge = 0; first = -1; run = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b0, '0, 1'b0);
      else idle();
      tick(); n_vec++;
      if (i == 0) req_edge = cyc;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL burst_rd cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
      if (a_rvalid1 === 1'b1) begin
        if (first < 0) first = cyc;
        if (a_rd1 === W'(run) && cyc == first + run) run++;
      end
    end
    n_vec++;
    if (first != req_edge + 1)
      begin n_bad++; $display("FAIL burst_start: got edge %0d want %0d", first, req_edge + 1); end
    n_vec++;
    if (run != 10) begin n_bad++; $display("FAIL burst_run: got %0d want 10", run); end
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 1'b1, 4'hf, 8'd20, 32'hAABBCCDD, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'b0101, 8'd20, 32'h11223344, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'h0, 8'd20, '0, 1'b0, '0, 1'b0); tick();
    n_vec++;
    if (a_rd0 !== 32'hAA22CC44 || a_rvalid0 !== 1'b1)
      begin n_bad++; $display("FAIL byte_en_lat1: got %h/%b want aa22cc44/1", a_rd0, a_rvalid0); end
    idle(); tick();
    n_vec++;
    if (a_rd1 !== 32'hAA22CC44 || a_rvalid1 !== 1'b1)
      begin n_bad++; $display("FAIL byte_en_lat2: got %h/%b want aa22cc44/1", a_rd1, a_rvalid1); end
    n_vec++;
    if (obs_now() !== exp_now())
      begin n_bad++; $display("FAIL byte_en_model: got %h want %h", obs_now(), exp_now()); end
  endtask

  task automatic test_rdw();
    drive(1'b1, 1'b1, 4'hf, 8'd3, 32'h12, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'hf, 8'd3, 32'h55, 1'b1, 8'd3, 1'b0); tick();
    n_vec++;
    if (b_rd0 !== 32'h12 || b_rvalid0 !== 1'b1)
      begin n_bad++; $display("FAIL rdw_old: got %h/%b want 12/1", b_rd0, b_rvalid0); end
    drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 8'd3, 1'b0); tick();
    n_vec++;
    if (b_rd1 !== 32'h55 || b_rvalid1 !== 1'b1)
      begin n_bad++; $display("FAIL rdw_new: got %h/%b want 55/1", b_rd1, b_rvalid1); end
    n_vec++;
    if (b_rd0 !== 32'h55)
      begin n_bad++; $display("FAIL rdw_after: got %h want 55", b_rd0); end
    idle(); tick();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b1, 4'hf, 8'd210, 32'hDEADBEEF, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'h0, 8'd210, '0, 1'b1, 8'd210, 1'b0); tick();
    n_vec++;
    if ({b_rvalid0, b_rd0} !== {1'b1, 32'h0})
      begin n_bad++; $display("FAIL oor_read: got %b/%h want 1/0", b_rvalid0, b_rd0); end
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1'b1, 1'b0, 4'h0, AW'(10 + 72 * i), '0, 1'b1, AW'(199 - i), 1'b0);
      else idle();
      tick(); n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL oor_array cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end
  endtask

  task automatic test_clr_busy();
    int n;
    drive(1'b1, 1'b0, 4'h0, 8'd5, '0, 1'b0, '0, 1'b1); tick();
    n_vec++;
    if ({busy0, a_rvalid0, a_rd0} !== {1'b1, 1'b1, 32'd5})
      begin n_bad++; $display("FAIL clr_with_read: got %b%b/%h want 11/5", busy0, a_rvalid0, a_rd0); end
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, i[0], 4'hf, 8'd6, 32'hCAFE, 1'b1, 8'd7, 1'b1);
      tick(); n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL busy_drop cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
      if (i == 0) begin
        n_vec++;
        if ({a_rvalid1, a_rd1, a_rvalid0} !== {1'b1, 32'd5, 1'b0})
          begin n_bad++; $display("FAIL inflight_finish: got %b/%h/%b want 1/5/0", a_rvalid1, a_rd1, a_rvalid0); end
      end
    end
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_now() !== exp_now())
      begin n_bad++; $display("FAIL midclear_reset: got %h want %h", obs_now(), exp_now()); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick(); n++; n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL reclear cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end while (busy0 === 1'b1 && n < int'(L) + 20);
    n_vec++;
    if (n != int'(L)) begin n_bad++; $display("FAIL reclear_len: got %0d edges want %0d", n, L); end
  endtask

  task automatic test_reset_midread();
    int n;
    drive(1'b1, 1'b1, 4'hf, 8'd5, 32'h77, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'h0, 8'd5, '0, 1'b1, 8'd5, 1'b0); tick();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({busy1, a_rvalid1, a_rd1, b_rvalid1, b_rd1} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0})
      begin n_bad++; $display("FAIL midread_reset: got %b%b/%h/%b/%h want 10/0/0/0", busy1, a_rvalid1, a_rd1, b_rvalid1, b_rd1); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick(); n++; n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL midread_lost cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end while (busy0 === 1'b1 && n < int'(L) + 20);
    n_vec++;
    if (n != int'(L)) begin n_bad++; $display("FAIL midread_clear_len: got %0d edges want %0d", n, L); end
  endtask

  task automatic test_random();
    logic [AW-1:0] aa, ba;
    for (int i = 0; i < 1500; i++) begin
      aa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 255));
      ba = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            aa, $urandom, 1'($urandom_range(0, 3) != 0), ba, 1'($urandom_range(0, 299) == 0));
      tick(); n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(); n_vec++;
      if (obs_now() !== exp_now())
        begin n_bad++; $display("FAIL random_drain cyc %0d: got %h want %h", cyc, obs_now(), exp_now()); end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_clr_busy();
    test_reset_midread();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
